control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port Stop, input, 1, level request to halt after the current instruction completes.
REQ-004 SHALL have port IR, input, 32, current instruction register contents; opcode is IR[31:27].
REQ-005 SHALL have outputs PCout, ZLowout, ZHighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, each 1 bit, wired to the datapath strobes of the same names.
REQ-006 SHALL have outputs GRA, GRB, GRC, Rin, Rout, BAout, Cout, HIin, LOin, each 1 bit; these are the register-select and HI/LO enables.
REQ-007 SHALL have output operation, 5 bits, ALU operation code.
REQ-008 SHALL have output Run, 1 bit, high while the sequencer is executing.

Function
REQ-009 SHALL be a Moore machine: every output is a function of the state register and IR only; outputs not listed for a state SHALL be 0.
REQ-010 SHALL implement states RST, T0, T1, T2, T3, T4, T5, T6, HALT.
REQ-011 T0: PCout, MARin, IncPC, Zin high.
REQ-012 T1: ZLowout, PCin, Read, MDRin high. Memory read completes in one cycle.
REQ-013 T2: MDRout, IRin high; IR is valid from T3 onward.
REQ-014 Opcode decode: add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010; addi 01100, andi 01101, ori 01110; mul 01111, div 10000; neg 10001, not 10010; nop 11010; halt 11011.
REQ-015 The two-operand ALU ops (add through rol) SHALL sequence as follows. T3: GRB, Rout, Yin. T4: GRC, Rout, Zin, with operation=opcode. T5: ZLowout, GRA, Rin. T5 then goes to T0.
REQ-016 Immediate ops (addi, andi, ori) SHALL sequence as follows. T3: GRB, Rout, Yin. T4: Cout, Zin, with operation=add (00011) for addi, and (00101) for andi, or (00110) for ori. T5: ZLowout, GRA, Rin. T5 then goes to T0.
REQ-017 neg and not SHALL sequence as follows. T3: GRB, Rout, Zin, with operation=opcode. T4: ZLowout, GRA, Rin. T4 then goes to T0.
REQ-018 nop and undefined opcodes SHALL go from T2 directly to T0 with no register write.
REQ-019 halt SHALL go from T2 to HALT. HALT SHALL hold all strobes 0 and Run=0 until Reset.
REQ-020 operation SHALL be 00000 in every state other than those listed in REQ-015 to REQ-017 and REQ-024.
REQ-021 The Stop input SHALL be sampled only on the final execute state of an instruction. If Stop is high there, the next state SHALL be HALT instead of T0. Stop SHALL never truncate an instruction.
REQ-022 The sequencer SHALL assert at most one of PCout, ZLowout, ZHighout, MDRout, Rout, Cout per state (single bus driver).

Reset
REQ-023 Reset high SHALL force state RST immediately, regardless of Clock. In RST, all strobes SHALL be 0, operation SHALL be 00000, and Run SHALL be 0. The first rising Clock edge with Reset low SHALL enter T0 with Run=1. Reset asserted mid-instruction (any of T0 to T6) SHALL abandon the instruction with no further strobes.

Configuration
REQ-024 With macro MULDIV_EN defined, mul and div SHALL sequence as follows. T3: GRA, Rout, Yin. T4: GRB, Rout, Zin, with operation=opcode. T5: ZLowout, LOin. T6: ZHighout, HIin. T6 then goes to T0.
REQ-025 Without MULDIV_EN, opcodes 01111 and 10000 SHALL be treated as undefined (REQ-018), and T6 SHALL be unreachable.

Verification
REQ-026 Scenario: Reset pulse, then IR=0x2A1B8000 (and). Required: T0, T1, T2; then GRB+Rout+Yin; then GRC+Rout+Zin with operation=00101; then ZLowout+GRA+Rin; then T0. Run=1 throughout.
REQ-027 Scenario: IR=0x61180005 (addi). Required: the T4 cycle shows Cout+Zin with operation=00011, and Rout=0 in that cycle.
REQ-028 Scenario: IR opcode 01111 with MULDIV_EN. Required: LOin in T5, then HIin with ZHighout in T6, then T0. Without MULDIV_EN, required: T2 goes directly to T0.
REQ-029 Scenario: IR=0xD8000000 (halt). Required: HALT is entered after T2 and Run=0. Thirty further clocks cause no strobe activity.
REQ-030 Scenario: Stop raised during the T3 of an and instruction. Required: T4 and T5 complete, then HALT is entered. Reset assertion mid-T4 returns the outputs to 0 asynchronously, before the next Clock edge.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Strobe and instruction bundle between the control sequencer (master) and
// the datapath (slave).
interface control_sequencer_if;
  logic        Stop;
  logic [31:0] IR;

  logic PCout, ZLowout, ZHighout, MDRout, MARin, Zin;
  logic PCin, MDRin, IRin, Yin, IncPC, Read;
  logic GRA, GRB, GRC, Rin, Rout, BAout, Cout, HIin, LOin;
  logic [4:0] operation;
  logic Run;

  modport master (
    input  Stop, IR,
    output PCout, ZLowout, ZHighout, MDRout, MARin, Zin,
           PCin, MDRin, IRin, Yin, IncPC, Read,
           GRA, GRB, GRC, Rin, Rout, BAout, Cout, HIin, LOin,
           operation, Run
  );

  modport slave (
    output Stop, IR,
    input  PCout, ZLowout, ZHighout, MDRout, MARin, Zin,
           PCin, MDRin, IRin, Yin, IncPC, Read,
           GRA, GRB, GRC, Rin, Rout, BAout, Cout, HIin, LOin,
           operation, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2), per-opcode execute (T3-T6), HALT.
// Define MULDIV_EN to sequence mul/div; otherwise they decode as undefined.
module control_sequencer (
  input logic                 Clock,
  input logic                 Reset,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_ALU, C_IMM, C_UNARY, C_MULDIV, C_HALT
  } op_class_t;

  typedef struct packed {
    logic PCout, ZLowout, ZHighout, MDRout, MARin, Zin;
    logic PCin, MDRin, IRin, Yin, IncPC, Read;
    logic GRA, GRB, GRC, Rin, Rout, BAout, Cout, HIin, LOin;
    logic [4:0] operation;
    logic Run;
  } ctrl_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  function automatic op_class_t classify(input logic [4:0] op);
    op_class_t k;
    k = C_NONE;
    if (op >= OP_ADD && op <= OP_ROL) k = C_ALU;
    else begin
      case (op)
        OP_ADDI, OP_ANDI, OP_ORI: k = C_IMM;
        OP_NEG, OP_NOT:           k = C_UNARY;
        OP_HALT:                  k = C_HALT;
`ifdef MULDIV_EN
        OP_MUL, OP_DIV:           k = C_MULDIV;
`else
        OP_MUL, OP_DIV:           k = C_NONE;
`endif
        default:                  k = C_NONE;
      endcase
    end
    return k;
  endfunction

  function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

  // Strobes for a state; at most one bus driver (PCout/ZLowout/ZHighout/
  // MDRout/Rout/Cout) is ever set per state.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [4:0] op);
    ctrl_t     c;
    op_class_t k;
    c = '0;
    k = classify(op);
    c.Run = (s != S_RST) && (s != S_HALT);
    case (s)
      S_T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; end
      S_T1: begin c.ZLowout = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
      S_T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      S_T3: begin
        case (k)
          C_ALU, C_IMM: begin c.GRB = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
          C_UNARY:      begin c.GRB = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.operation = op; end
          C_MULDIV:     begin c.GRA = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
          default:      ;
        endcase
      end
      S_T4: begin
        case (k)
          C_ALU:    begin c.GRC = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.operation = op; end
          C_IMM:    begin c.Cout = 1'b1; c.Zin = 1'b1; c.operation = imm_alu_op(op); end
          C_UNARY:  begin c.ZLowout = 1'b1; c.GRA = 1'b1; c.Rin = 1'b1; end
          C_MULDIV: begin c.GRB = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; c.operation = op; end
          default:  ;
        endcase
      end
      S_T5: begin
        case (k)
          C_ALU, C_IMM: begin c.ZLowout = 1'b1; c.GRA = 1'b1; c.Rin = 1'b1; end
          C_MULDIV:     begin c.ZLowout = 1'b1; c.LOin = 1'b1; end
          default:      ;
        endcase
      end
      S_T6: if (k == C_MULDIV) begin c.ZHighout = 1'b1; c.HIin = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  logic [4:0] opcode;
  logic       unused_ir;
  assign opcode    = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];

  state_t    state, state_nxt;
  ctrl_t     ctrl, ctrl_nxt;
  op_class_t op_class;
  logic      final_step;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    op_class   = classify(opcode);
    state_nxt  = state;
    final_step = 1'b0;
    case (state)
      S_RST:  state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2: begin
        case (op_class)
          C_HALT:  state_nxt = S_HALT;
          C_NONE:  final_step = 1'b1;
          default: state_nxt = S_T3;
        endcase
      end
      S_T3:   state_nxt = S_T4;
      S_T4:   if (op_class == C_UNARY) final_step = 1'b1; else state_nxt = S_T5;
      S_T5:   if (op_class == C_MULDIV) state_nxt = S_T6; else final_step = 1'b1;
      S_T6:   final_step = 1'b1;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
    // Stop only redirects the step after an instruction's last execute state.
    if (final_step) state_nxt = bus.Stop ? S_HALT : S_T0;
    ctrl_nxt = decode_ctrl(state_nxt, opcode);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; outputs are registered alongside the state so
  // they are glitch-free and clear asynchronously with it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_RST;
      ctrl  <= '0;
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_nxt;
    end
  end

  assign bus.PCout     = ctrl.PCout;
  assign bus.ZLowout   = ctrl.ZLowout;
  assign bus.ZHighout  = ctrl.ZHighout;
  assign bus.MDRout    = ctrl.MDRout;
  assign bus.MARin     = ctrl.MARin;
  assign bus.Zin       = ctrl.Zin;
  assign bus.PCin      = ctrl.PCin;
  assign bus.MDRin     = ctrl.MDRin;
  assign bus.IRin      = ctrl.IRin;
  assign bus.Yin       = ctrl.Yin;
  assign bus.IncPC     = ctrl.IncPC;
  assign bus.Read      = ctrl.Read;
  assign bus.GRA       = ctrl.GRA;
  assign bus.GRB       = ctrl.GRB;
  assign bus.GRC       = ctrl.GRC;
  assign bus.Rin       = ctrl.Rin;
  assign bus.Rout      = ctrl.Rout;
  assign bus.BAout     = ctrl.BAout;
  assign bus.Cout      = ctrl.Cout;
  assign bus.HIin      = ctrl.HIin;
  assign bus.LOin      = ctrl.LOin;
  assign bus.operation = ctrl.operation;
  assign bus.Run       = ctrl.Run;

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer: per-cycle expected strobe words
// queued per instruction, plus hand-written Stop/halt/reset sequences.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Reset;

  control_sequencer_if bus ();

  control_sequencer dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic PCout, ZLowout, ZHighout, MDRout, MARin, Zin;
    logic PCin, MDRin, IRin, Yin, IncPC, Read;
    logic GRA, GRB, GRC, Rin, Rout, BAout, Cout, HIin, LOin;
    logic [4:0] operation;
    logic Run;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          n;
    obs_t        exp [0:7];
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  obs_t exp_q [$];
  vec_t vecs  [$];

  task automatic check(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.PCout = bus.PCout;   o.ZLowout = bus.ZLowout; o.ZHighout = bus.ZHighout;
    o.MDRout = bus.MDRout; o.MARin = bus.MARin;     o.Zin = bus.Zin;
    o.PCin = bus.PCin;     o.MDRin = bus.MDRin;     o.IRin = bus.IRin;
    o.Yin = bus.Yin;       o.IncPC = bus.IncPC;     o.Read = bus.Read;
    o.GRA = bus.GRA;       o.GRB = bus.GRB;         o.GRC = bus.GRC;
    o.Rin = bus.Rin;       o.Rout = bus.Rout;       o.BAout = bus.BAout;
    o.Cout = bus.Cout;     o.HIin = bus.HIin;       o.LOin = bus.LOin;
    o.operation = bus.operation;
    o.Run = bus.Run;
    return o;
  endfunction

  // Expected strobe words, written out from the state descriptions.
  function automatic obs_t w_run();
    obs_t o = '0; o.Run = 1'b1; return o;
  endfunction
  function automatic obs_t w_t0();
    obs_t o = w_run(); o.PCout = 1; o.MARin = 1; o.IncPC = 1; o.Zin = 1; return o;
  endfunction
  function automatic obs_t w_t1();
    obs_t o = w_run(); o.ZLowout = 1; o.PCin = 1; o.Read = 1; o.MDRin = 1; return o;
  endfunction
  function automatic obs_t w_t2();
    obs_t o = w_run(); o.MDRout = 1; o.IRin = 1; return o;
  endfunction
  function automatic obs_t w_rb_y();
    obs_t o = w_run(); o.GRB = 1; o.Rout = 1; o.Yin = 1; return o;
  endfunction
  function automatic obs_t w_ra_y();
    obs_t o = w_run(); o.GRA = 1; o.Rout = 1; o.Yin = 1; return o;
  endfunction
  function automatic obs_t w_rc_z(input logic [4:0] op);
    obs_t o = w_run(); o.GRC = 1; o.Rout = 1; o.Zin = 1; o.operation = op; return o;
  endfunction
  function automatic obs_t w_rb_z(input logic [4:0] op);
    obs_t o = w_run(); o.GRB = 1; o.Rout = 1; o.Zin = 1; o.operation = op; return o;
  endfunction
  function automatic obs_t w_c_z(input logic [4:0] op);
    obs_t o = w_run(); o.Cout = 1; o.Zin = 1; o.operation = op; return o;
  endfunction
  function automatic obs_t w_wb();
    obs_t o = w_run(); o.ZLowout = 1; o.GRA = 1; o.Rin = 1; return o;
  endfunction
  function automatic obs_t w_lo();
    obs_t o = w_run(); o.ZLowout = 1; o.LOin = 1; return o;
  endfunction
  function automatic obs_t w_hi();
    obs_t o = w_run(); o.ZHighout = 1; o.HIin = 1; return o;
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] ir, input int n,
                              input obs_t e3, input obs_t e4, input obs_t e5, input obs_t e6);
    vec_t v;
    v.name = name; v.ir = ir; v.n = n;
    v.exp[0] = w_t0(); v.exp[1] = w_t1(); v.exp[2] = w_t2();
    v.exp[3] = e3; v.exp[4] = e4; v.exp[5] = e5; v.exp[6] = e6; v.exp[7] = '0;
    return v;
  endfunction

  // Drives IR just after the edge entering T0, optionally raises Stop just
  // after the edge entering cycle stop_at, and compares each cycle mid-period.
  task automatic run_vec(input vec_t v, input int stop_at);
    for (int i = 0; i < v.n; i++) exp_q.push_back(v.exp[i]);
    for (int i = 0; i < v.n; i++) begin
      @(posedge Clock); #1;
      if (i == 0) bus.IR = v.ir;
      if (i == stop_at) bus.Stop = 1'b1;
      @(negedge Clock);
      check($sformatf("%s cyc%0d", v.name, i), observe(), exp_q.pop_front());
    end
  endtask

  task automatic idle_zero(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clock); @(negedge Clock);
      check($sformatf("%s idle%0d", name, i), observe(), obs_t'('0));
    end
  endtask

  initial begin
    vec_t v;
    bus.Stop = 1'b0;
    bus.IR   = 32'h0;
    Reset    = 1'b1;

    vecs.push_back(mk("and",  32'h2A1B8000, 6, w_rb_y(), w_rc_z(5'b00101), w_wb(), '0));
    vecs.push_back(mk("add",  {5'b00011, 27'h0123456}, 6, w_rb_y(), w_rc_z(5'b00011), w_wb(), '0));
    vecs.push_back(mk("sub",  {5'b00100, 27'h7ABCDEF}, 6, w_rb_y(), w_rc_z(5'b00100), w_wb(), '0));
    vecs.push_back(mk("shr",  {5'b00111, 27'h0000001}, 6, w_rb_y(), w_rc_z(5'b00111), w_wb(), '0));
    vecs.push_back(mk("rol",  {5'b01010, 27'h5555555}, 6, w_rb_y(), w_rc_z(5'b01010), w_wb(), '0));
    vecs.push_back(mk("addi", 32'h61180005, 6, w_rb_y(), w_c_z(5'b00011), w_wb(), '0));
    vecs.push_back(mk("andi", {5'b01101, 27'h0000FFF}, 6, w_rb_y(), w_c_z(5'b00101), w_wb(), '0));
    vecs.push_back(mk("ori",  {5'b01110, 27'h2000000}, 6, w_rb_y(), w_c_z(5'b00110), w_wb(), '0));
    vecs.push_back(mk("neg",  {5'b10001, 27'h0000010}, 5, w_rb_z(5'b10001), w_wb(), '0, '0));
    vecs.push_back(mk("not",  {5'b10010, 27'h0000020}, 5, w_rb_z(5'b10010), w_wb(), '0, '0));
    vecs.push_back(mk("nop",  {5'b11010, 27'h7FFFFFF}, 3, '0, '0, '0, '0));
    vecs.push_back(mk("op00", {5'b00000, 27'h0}, 3, '0, '0, '0, '0));
    vecs.push_back(mk("op0B", {5'b01011, 27'h0}, 3, '0, '0, '0, '0));
    vecs.push_back(mk("op1F", {5'b11111, 27'h0}, 3, '0, '0, '0, '0));
`ifdef MULDIV_EN
    vecs.push_back(mk("mul", {5'b01111, 27'h0}, 7, w_ra_y(), w_rb_z(5'b01111), w_lo(), w_hi()));
    vecs.push_back(mk("div", {5'b10000, 27'h0}, 7, w_ra_y(), w_rb_z(5'b10000), w_lo(), w_hi()));
`else
    vecs.push_back(mk("mul", {5'b01111, 27'h0}, 3, '0, '0, '0, '0));
    vecs.push_back(mk("div", {5'b10000, 27'h0}, 3, '0, '0, '0, '0));
`endif
    vecs.push_back(mk("and2", 32'h2A1B8000, 6, w_rb_y(), w_rc_z(5'b00101), w_wb(), '0));

    #12;
    check("reset state", observe(), obs_t'('0));
    @(negedge Clock);
    Reset = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k], -1);

    // Stop raised in T3 of an and: T4 and T5 still complete, then HALT.
    v = mk("and_stop", 32'h2A1B8000, 7, w_rb_y(), w_rc_z(5'b00101), w_wb(), '0);
    run_vec(v, 3);
    bus.Stop = 1'b0;
    idle_zero("after_stop", 5);

    // Reset pulse, then halt instruction; HALT must stay silent.
    Reset = 1'b1; #1;
    check("reset from halt", observe(), obs_t'('0));
    @(negedge Clock);
    Reset = 1'b0;
    v = mk("halt", 32'hD8000000, 4, '0, '0, '0, '0);
    run_vec(v, -1);
    idle_zero("halted", 30);

    // Reset mid-T4 clears outputs before the next clock edge.
    Reset = 1'b1; #1;
    @(negedge Clock);
    Reset = 1'b0;
    v = mk("and_cut", 32'h2A1B8000, 5, w_rb_y(), w_rc_z(5'b00101), '0, '0);
    run_vec(v, -1);
    #2 Reset = 1'b1;
    #1;
    check("async reset mid-T4", observe(), obs_t'('0));
    @(negedge Clock);
    Reset = 1'b0;
    run_vec(mk("nop_after_reset", {5'b11010, 27'h0}, 3, '0, '0, '0, '0), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
